// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/redirect controller for the 5-stage pipeline.
// Handles load-use, branches, memory waits, divides, MEM exceptions.
module pipeline_hazard_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_rs1_used,
    input  logic             i_id_rs2_used,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_mem_read,
    input  logic             i_ex_is_div,
    input  logic             i_ex_br_taken,
    input  logic [XLEN-1:0]  i_ex_br_target,
    input  logic             i_mem_exc,
    input  logic [XLEN-1:0]  i_mem_pc,
    input  logic             i_div_done,
    input  logic             i_dmem_wait,
    input  logic             i_imem_wait,
    output logic             o_pc_stall,
    output logic             o_if_id_stall,
    output logic             o_id_ex_stall,
    output logic             o_ex_mem_stall,
    output logic             o_if_id_flush,
    output logic             o_id_ex_flush,
    output logic             o_ex_mem_flush,
    output logic             o_mem_wb_flush,
    output logic             o_pc_redirect,
    output logic [XLEN-1:0]  o_redirect_pc,
    output logic             o_div_start,
    output logic             o_div_kill,
    output logic [XLEN-1:0]  o_epc,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN,
        S_DIV_WAIT,
        S_TRAP
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [XLEN-1:0]  r_epc;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic            w_load_use;
    logic            w_pc_stall;
    logic            w_if_id_stall;
    logic            w_id_ex_stall;
    logic            w_ex_mem_stall;
    logic            w_if_id_flush;
    logic            w_id_ex_flush;
    logic            w_ex_mem_flush;
    logic            w_mem_wb_flush;
    logic            w_pc_redirect;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_div_start;
    logic            w_div_kill;
    logic            w_epc_ld;

    assign w_load_use = i_ex_mem_read && (i_ex_rd != 5'd0) &&
                        ((i_id_rs1_used && (i_id_rs1 == i_ex_rd)) ||
                         (i_id_rs2_used && (i_id_rs2 == i_ex_rd)));

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_stall     = 1'b0;
        w_if_id_stall  = 1'b0;
        w_id_ex_stall  = 1'b0;
        w_ex_mem_stall = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_flush = 1'b0;
        w_mem_wb_flush = 1'b0;
        w_pc_redirect  = 1'b0;
        w_redirect_pc  = '0;
        w_div_start    = 1'b0;
        w_div_kill     = 1'b0;
        w_epc_ld       = 1'b0;
        unique case (r_state)
            S_RUN: begin
                if (i_mem_exc) begin
                    w_pc_stall     = 1'b1;
                    w_if_id_flush  = 1'b1;
                    w_id_ex_flush  = 1'b1;
                    w_ex_mem_flush = 1'b1;
                    w_mem_wb_flush = 1'b1;
                    w_epc_ld       = 1'b1;
                    w_state_nxt    = S_TRAP;
                end else if (i_dmem_wait) begin
                    w_pc_stall     = 1'b1;
                    w_if_id_stall  = 1'b1;
                    w_id_ex_stall  = 1'b1;
                    w_ex_mem_stall = 1'b1;
                    w_mem_wb_flush = 1'b1;
                end else if (i_ex_is_div) begin
                    w_div_start    = 1'b1;
                    w_pc_stall     = 1'b1;
                    w_if_id_stall  = 1'b1;
                    w_id_ex_stall  = 1'b1;
                    w_ex_mem_flush = 1'b1;
                    w_state_nxt    = S_DIV_WAIT;
                end else if (i_ex_br_taken) begin
                    w_pc_redirect  = 1'b1;
                    w_redirect_pc  = i_ex_br_target;
                    w_if_id_flush  = 1'b1;
                    w_id_ex_flush  = 1'b1;
                end else if (w_load_use) begin
                    w_pc_stall     = 1'b1;
                    w_if_id_stall  = 1'b1;
                    w_id_ex_flush  = 1'b1;
                end else if (i_imem_wait) begin
                    w_pc_stall     = 1'b1;
                    w_if_id_flush  = 1'b1;
                end
            end
            S_DIV_WAIT: begin
                if (i_mem_exc) begin
                    w_div_kill     = 1'b1;
                    w_pc_stall     = 1'b1;
                    w_if_id_flush  = 1'b1;
                    w_id_ex_flush  = 1'b1;
                    w_ex_mem_flush = 1'b1;
                    w_mem_wb_flush = 1'b1;
                    w_epc_ld       = 1'b1;
                    w_state_nxt    = S_TRAP;
                end else if (i_dmem_wait) begin
                    w_pc_stall     = 1'b1;
                    w_if_id_stall  = 1'b1;
                    w_id_ex_stall  = 1'b1;
                    w_ex_mem_stall = 1'b1;
                    w_mem_wb_flush = 1'b1;
                end else if (i_div_done) begin
                    // EX/MEM is left free to capture the quotient
                    w_state_nxt    = S_RUN;
                end else begin
                    w_pc_stall     = 1'b1;
                    w_if_id_stall  = 1'b1;
                    w_id_ex_stall  = 1'b1;
                    w_ex_mem_flush = 1'b1;
                end
            end
            S_TRAP: begin
                w_pc_redirect  = 1'b1;
                w_redirect_pc  = TRAP_VEC;
                w_if_id_flush  = 1'b1;
                w_id_ex_flush  = 1'b1;
                w_ex_mem_flush = 1'b1;
                w_mem_wb_flush = 1'b1;
                w_state_nxt    = S_RUN;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    // Reset must silence the pipeline controls without waiting for a clock
    assign o_pc_stall     = rst_n & w_pc_stall;
    assign o_if_id_stall  = rst_n & w_if_id_stall;
    assign o_id_ex_stall  = rst_n & w_id_ex_stall;
    assign o_ex_mem_stall = rst_n & w_ex_mem_stall;
    assign o_if_id_flush  = rst_n & w_if_id_flush;
    assign o_id_ex_flush  = rst_n & w_id_ex_flush;
    assign o_ex_mem_flush = rst_n & w_ex_mem_flush;
    assign o_mem_wb_flush = rst_n & w_mem_wb_flush;
    assign o_pc_redirect  = rst_n & w_pc_redirect;
    assign o_redirect_pc  = rst_n ? w_redirect_pc : '0;
    assign o_div_start    = rst_n & w_div_start;
    assign o_div_kill     = rst_n & w_div_kill;
    assign o_epc          = r_epc;
    assign o_stall_cnt    = r_stall_cnt;
    assign o_flush_cnt    = r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_epc       <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_epc_ld)
                r_epc <= i_mem_pc;
            if (w_pc_stall)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_pc_redirect)
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios, then random
// traffic against a pipeline-depth model of the hazard rules.
module tb_pipeline_hazard_ctrl;

    localparam int          XLEN = 32;
    localparam logic [31:0] TV   = 32'h0000_0100;
    localparam int          CW   = 4;
    localparam int          CMOD = 16;
    localparam int          M_RUN  = 0;
    localparam int          M_DIV  = 1;
    localparam int          M_TRAP = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic id_rs1_used = 0, id_rs2_used = 0, ex_mem_read = 0;
    logic ex_is_div = 0, ex_br_taken = 0, mem_exc = 0;
    logic div_done = 0, dmem_wait = 0, imem_wait = 0;
    logic [31:0] ex_br_target = '0, mem_pc = '0;

    logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic pc_redirect, div_start, div_kill;
    logic [31:0] redirect_pc, epc;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .XLEN(XLEN), .TRAP_VEC(TV), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_rs1_used(id_rs1_used), .i_id_rs2_used(id_rs2_used),
        .i_ex_rd(ex_rd), .i_ex_mem_read(ex_mem_read),
        .i_ex_is_div(ex_is_div), .i_ex_br_taken(ex_br_taken),
        .i_ex_br_target(ex_br_target),
        .i_mem_exc(mem_exc), .i_mem_pc(mem_pc),
        .i_div_done(div_done), .i_dmem_wait(dmem_wait),
        .i_imem_wait(imem_wait),
        .o_pc_stall(pc_stall), .o_if_id_stall(if_id_stall),
        .o_id_ex_stall(id_ex_stall), .o_ex_mem_stall(ex_mem_stall),
        .o_if_id_flush(if_id_flush), .o_id_ex_flush(id_ex_flush),
        .o_ex_mem_flush(ex_mem_flush), .o_mem_wb_flush(mem_wb_flush),
        .o_pc_redirect(pc_redirect), .o_redirect_pc(redirect_pc),
        .o_div_start(div_start), .o_div_kill(div_kill),
        .o_epc(epc), .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: pipeline registers indexed 0=IF/ID .. 3=MEM/WB
    int m_mode = M_RUN;
    logic [31:0] m_epc = '0;
    int m_sc = 0, m_fc = 0;
    int dcount = 0, div_lat = 4, n_ds = 0;
    int n_mode;
    logic e_pcs, e_rd, e_ds, e_dk, e_epc;
    logic [2:0] e_st;
    logic [3:0] e_fl;
    logic [31:0] e_rpc;

    wire [2:0] obs_st = {ex_mem_stall, id_ex_stall, if_id_stall};
    wire [3:0] obs_fl = {mem_wb_flush, ex_mem_flush, id_ex_flush, if_id_flush};

    function automatic bit lu();
        bit [4:0] srcs[$];
        if (!ex_mem_read || ex_rd == 5'd0) return 0;
        if (id_rs1_used) srcs.push_back(id_rs1);
        if (id_rs2_used) srcs.push_back(id_rs2);
        foreach (srcs[i]) if (srcs[i] == ex_rd) return 1;
        return 0;
    endfunction

    // Freeze PC and the n registers in front, bubble register n
    task automatic hold(int n);
        e_pcs = 1'b1;
        for (int i = 0; i < n; i++) e_st[i] = 1'b1;
        e_fl[n] = 1'b1;
    endtask

    task automatic predict();
        e_pcs = 0; e_st = '0; e_fl = '0; e_rd = 0;
        e_ds = 0; e_dk = 0; e_rpc = '0; e_epc = 0;
        n_mode = m_mode;
        if (!rst_n) return;
        if (m_mode == M_TRAP) begin
            e_rd = 1; e_rpc = TV; e_fl = 4'hF; n_mode = M_RUN;
        end else if (mem_exc) begin
            e_pcs = 1; e_fl = 4'hF; e_epc = 1;
            e_dk = (m_mode == M_DIV); n_mode = M_TRAP;
        end else if (dmem_wait) begin
            hold(3);
        end else if (m_mode == M_DIV) begin
            if (div_done) n_mode = M_RUN;
            else hold(2);
        end else if (ex_is_div) begin
            e_ds = 1; hold(2); n_mode = M_DIV;
        end else if (ex_br_taken) begin
            e_rd = 1; e_rpc = ex_br_target; e_fl = 4'b0011;
        end else if (lu()) begin
            hold(1);
        end else if (imem_wait) begin
            hold(0);
        end
    endtask

    // One clock: called at a negedge with inputs already applied
    task automatic step();
        if (dcount > 0) begin
            dcount--;
            if (dcount == 0) div_done = 1'b1;
        end
        #1;
        predict();
        chk("ctl", {pc_stall, obs_st, obs_fl, pc_redirect, div_start, div_kill},
                   {e_pcs, e_st, e_fl, e_rd, e_ds, e_dk});
        if (e_rd) chk("rpc", redirect_pc, e_rpc);
        n_ds += int'(div_start);
        if (!rst_n) begin
            m_mode = M_RUN; m_epc = '0; m_sc = 0; m_fc = 0;
            dcount = 0; div_done = 1'b0;
            chk("rst_epc", epc, 0);
            chk("rst_scnt", stall_cnt, 0);
            chk("rst_fcnt", flush_cnt, 0);
        end
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (e_epc) m_epc = mem_pc;
            if (e_pcs) m_sc = (m_sc + 1) % CMOD;
            if (e_rd) m_fc = (m_fc + 1) % CMOD;
            m_mode = n_mode;
            if (e_ds) begin dcount = div_lat; div_done = 1'b0; end
            if (e_dk) begin dcount = 0; div_done = 1'b0; end
        end
        chk("epc", epc, m_epc);
        chk("scnt", stall_cnt, m_sc);
        chk("fcnt", flush_cnt, m_fc);
        @(negedge clk);
    endtask

    task automatic clr();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_rs1_used = 0; id_rs2_used = 0; ex_mem_read = 0;
        ex_is_div = 0; ex_br_taken = 0; mem_exc = 0;
        dmem_wait = 0; imem_wait = 0;
        ex_br_target = '0; mem_pc = '0;
    endtask

    int s0, d0;

    initial begin
        @(negedge clk);
        step();
        rst_n = 1'b1;
        step();

        // load-use bubble
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1;
        step();
        clr();
        step();
        chk("t1_scnt", stall_cnt, 1);

        // taken branch beats load-use
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1;
        ex_br_taken = 1; ex_br_target = 32'h200;
        step();
        chk("t2_rpc", redirect_pc, 32'h200);
        chk("t2_nostall", {pc_stall, if_id_stall}, 0);
        clr();

        // divide, done four cycles after start
        s0 = m_sc; d0 = n_ds;
        ex_is_div = 1; div_lat = 4;
        step();
        ex_is_div = 0;
        repeat (4) step();
        chk("t3_stalls", (int'(stall_cnt) - s0 + CMOD) % CMOD, 4);
        chk("t3_starts", n_ds - d0, 1);
        #1 chk("t3_run", pc_stall, 0);
        step();

        // exception while waiting on a divide
        ex_is_div = 1; div_lat = 6;
        step();
        ex_is_div = 0;
        step();
        mem_exc = 1; mem_pc = 32'h4C;
        #1 chk("t4_kill", div_kill, 1);
        step();
        clr();
        chk("t4_epc", epc, 32'h4C);
        #1 chk("t4_trap", {pc_redirect, redirect_pc}, {1'b1, 32'h100});
        step();
        step();

        // data wait defers a taken branch
        dmem_wait = 1; ex_br_taken = 1; ex_br_target = 32'h300;
        repeat (3) begin
            #1 chk("t5_hold", {pc_redirect, mem_wb_flush}, 2'b01);
            step();
        end
        dmem_wait = 0;
        #1 chk("t5_redir", pc_redirect, 1);
        step();
        clr();

        // reset in the middle of a divide
        ex_is_div = 1; div_lat = 6;
        step();
        ex_is_div = 0;
        step();
        rst_n = 1'b0;
        #1 chk("t6_out", {pc_stall, obs_st, obs_fl}, 0);
        step();
        rst_n = 1'b1;
        step();
        #1 chk("t6_run", pc_stall, 0);

        repeat (3000) begin
            rst_n        = ($urandom_range(0, 149) != 0);
            mem_exc      = ($urandom_range(0, 19) == 0);
            mem_pc       = $urandom;
            dmem_wait    = ($urandom_range(0, 5) == 0);
            imem_wait    = ($urandom_range(0, 4) == 0);
            ex_is_div    = ($urandom_range(0, 9) == 0);
            ex_br_taken  = ($urandom_range(0, 3) == 0);
            ex_br_target = $urandom;
            ex_mem_read  = ($urandom_range(0, 2) == 0);
            ex_rd        = 5'($urandom_range(0, 3));
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            id_rs1_used  = 1'($urandom_range(0, 1));
            id_rs2_used  = 1'($urandom_range(0, 1));
            div_lat      = $urandom_range(1, 6);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
